// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the sum accumulator slice.
package sum_acc_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
    localparam int DATA_W = 8;
endpackage

// File: rtl/adder_8bit.sv
// 8-bit unsigned adder with carry-in; overflow is the carry out of bit 7.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {8'b0, carry_in};
endmodule

// File: rtl/sum_accumulator.sv
// Counted stream accumulator: folds N handshaked samples into a wrapping 8-bit
// total with a sticky carry flag, then pulses done for one cycle.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  sample_count,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow_flag
);
    acc_state_t        state, state_nx;
    logic [DATA_W-1:0] acc, acc_nx;
    logic              flag, flag_nx;
    logic [CNT_W-1:0]  remaining, remaining_nx;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    adder_8bit u_adder (
        .a        (acc),
        .b        (data_in),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        flag_nx      = flag;
        remaining_nx = remaining;
        data_ready   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                // A sample presented alongside start is deliberately not consumed.
                if (start) begin
                    acc_nx       = '0;
                    flag_nx      = 1'b0;
                    remaining_nx = sample_count;
                    state_nx     = (sample_count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (data_valid) begin
                    acc_nx       = add_sum;
                    flag_nx      = flag | add_ovf;
                    remaining_nx = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1))
                        state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            acc       <= '0;
            flag      <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            flag      <= flag_nx;
            remaining <= remaining_nx;
        end
    end

    assign result        = acc;
    assign overflow_flag = flag;
endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against an
// integer-sum reference model, compared on every falling edge.
module tb_sum_accumulator;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [CNT_W-1:0] sample_count;
    logic [7:0]       data_in;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic             done;
    logic [7:0]       result;
    logic             overflow_flag;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference: the run is an unbounded integer sum; wrap and flag fall out of it.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_rem  = 0;
    int m_sum  = 0;

    sum_accumulator #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .sample_count  (sample_count),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .overflow_flag (overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!n_rst) begin
            m_run = 0; m_done = 0; m_rem = 0; m_sum = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (start) begin
                m_sum = 0;
                if (sample_count == 0) m_done = 1;
                else begin m_run = 1; m_rem = int'(sample_count); end
            end
        end else if (data_valid) begin
            m_sum += int'(data_in);
            m_rem--;
            if (m_rem == 0) begin m_run = 0; m_done = 1; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_ready", 32'(data_ready), 32'(m_run));
            chk("busy", 32'(busy), 32'(m_run | m_done));
            chk("done", 32'(done), 32'(m_done));
            chk("result", 32'(result), 32'(m_sum % 256));
            chk("overflow_flag", 32'(overflow_flag), 32'(m_sum > 255));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; data_valid = 0; data_in = 0; sample_count = 0;
    endtask

    initial begin
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int k;

        // Reset held with start and data_valid asserted
        n_rst = 0; start = 1; sample_count = 3; data_valid = 1; data_in = 8'h55;
        tick(); chk_en = 1;
        tick();
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        n_rst = 1; idle_in(); tick();

        // Basic run 10, 20, 30
        start = 1; sample_count = 3; tick();
        start = 0; data_valid = 1; data_in = 10; tick();
        chk("basic_r1", 32'(result), 32'd10);
        data_in = 20; tick();
        chk("basic_r2", 32'(result), 32'd30);
        data_in = 30; tick();
        chk("basic_r3", 32'(result), 32'd60);
        chk("basic_done", 32'(done), 32'd1);
        idle_in(); tick();
        chk("basic_idle_busy", 32'(busy), 32'd0);

        // Overflow then clear
        start = 1; sample_count = 2; tick();
        start = 0; data_valid = 1; data_in = 200; tick();
        data_in = 100; tick();
        chk("ovf_result", 32'(result), 32'h2C);
        chk("ovf_flag", 32'(overflow_flag), 32'd1);
        idle_in(); tick(); tick();
        chk("ovf_flag_held", 32'(overflow_flag), 32'd1);
        start = 1; sample_count = 1; tick();
        chk("ovf_flag_clr", 32'(overflow_flag), 32'd0);
        start = 0; data_valid = 1; data_in = 5; tick();
        chk("clr_result", 32'(result), 32'd5);
        idle_in(); tick();

        // Backpressure with a stray start mid-run
        start = 1; sample_count = 4; tick();
        start = 0; k = 0;
        for (int i = 0; i < 7; i++) begin
            data_valid = pat[i];
            data_in    = 8'(k + 1);
            start        = (i == 2);
            sample_count = (i == 2) ? 4'd15 : 4'd4;
            tick();
            if (pat[i]) k++;
        end
        chk("bp_result", 32'(result), 32'd10);
        chk("bp_done", 32'(done), 32'd1);
        idle_in(); tick();

        // Zero-count run
        start = 1; sample_count = 0; data_valid = 1; data_in = 9; tick();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_result", 32'(result), 32'd0);
        idle_in(); tick();

        // Mid-run reset
        start = 1; sample_count = 4; tick();
        start = 0; data_valid = 1; data_in = 5; tick();
        data_in = 6; tick();
        data_valid = 0; n_rst = 0; tick();
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        n_rst = 1; start = 1; sample_count = 1; tick();
        start = 0; data_valid = 1; data_in = 7; tick();
        chk("mrst_fresh", 32'(result), 32'd7);
        idle_in(); tick();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            n_rst        = ($urandom_range(0, 99) != 0);
            start        = ($urandom_range(0, 3) == 0);
            sample_count = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            data_valid   = ($urandom_range(0, 2) != 0);
            data_in      = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(200, 255));
            tick();
        end

        idle_in(); n_rst = 1; tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
